pattern_scan_arbiter: RTL and testbench
=======================================

Name: pattern_scan_arbiter

Overview:
- Shares one bit-serial Moore-style pattern detector among 4 requesters.
- Each requester presents a WORD_W-bit word. The block arbitrates round-robin, serializes the granted word MSB-first through an internal overlapping detector for pattern PAT, and reports the match count with the requester id.
- Sits in front of the sequence-detector datapath as its scheduler and sequencer.

Parameters:
- WORD_W, 8, bits per request word.
- PAT_W, 3, pattern length; legal range 2..WORD_W.
- PAT, 3'b101, pattern matched; the first-received bit is PAT[PAT_W-1].
- CNT_W, 4, match_cnt width; must be at least clog2(WORD_W+1).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset; asynchronous, active-low.
- req  input  4  per-requester request, level.
- data  input  4*WORD_W  request words; requester i at data[i*WORD_W +: WORD_W].
- gnt  output  4  one-hot grant, one-cycle pulse.
- busy  output  1  high in every state except IDLE.
- ser_bit  output  1  bit currently fed to the detector.
- ser_valid  output  1  ser_bit valid.
- done  output  1  one-cycle result strobe.
- done_id  output  2  requester index of the result.
- match_cnt  output  CNT_W  matches found in the word.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (clr). All outputs are registered.
- Reset (clr=0), effective immediately:
  - state=IDLE.
  - gnt, busy, ser_bit, ser_valid, done, done_id, match_cnt all 0.
  - Round-robin pointer ptr=0.
  - Reset mid-operation aborts the word with no done. Output done_id/match_cnt are cleared.
- States: IDLE, LOAD, SHIFT, REPORT.
- IDLE:
  - If req is nonzero at a clock edge, the winner is the first set bit searching ptr, ptr+1, ... (mod 4).
  - On that same edge: capture the winner's word into the shift register, clear the detector history window and the bit counter, clear the internal count, go to LOAD.
- LOAD:
  - One cycle. gnt[winner]=1 and busy=1; the requester may then drop req.
  - Next state SHIFT.
- SHIFT:
  - WORD_W cycles. Each cycle: ser_bit = shift-register MSB, ser_valid=1, then shift left.
  - Detector update: win_next = {win[PAT_W-2:0], ser_bit}.
  - If (bits_seen+1) >= PAT_W and win_next == PAT, the count increments.
  - Matching is overlapping, as in the 101 Moore detector.
  - After the WORD_W-th bit, go to REPORT.
- REPORT:
  - One cycle. done=1; done_id=winner; match_cnt=count.
  - done_id and match_cnt hold until the next REPORT or reset.
  - ptr = winner+1 mod 4. Next state IDLE.
- Latency: req sampled in IDLE at edge 0 → gnt in cycle 1, ser_valid in cycles 2..WORD_W+1, done in cycle WORD_W+2. Throughput is one word per WORD_W+3 cycles with continuous requests.
- History does not carry across words: every word starts with an empty window.
- A req deasserted before the IDLE sampling edge is not served. A req still high when IDLE is re-entered is served again; this is a new request.
- Requests arriving while busy wait. There is no queueing beyond req staying high.
- Maximum count is WORD_W-PAT_W+1 and never overflows CNT_W.

Test Plan:
- Reset abort: start a word, pull clr=0 during SHIFT bit 4 → all outputs 0 within the cycle, no done; after release with req=0, state stays IDLE and busy=0.
- Single request: req=4'b0001, data0=8'b10101010 → gnt=0001 at cycle 1; ser_bit sequence 1,0,1,0,1,0,1,0 in cycles 2..9; done at cycle 10 with done_id=0, match_cnt=3.
- Overlap count: data0=8'b10110101 → match_cnt=3. data0=8'hFF → match_cnt=0. data0=8'b00000101 → match_cnt=1.
- No cross-word history: req0 with 8'b00000010, then req0 with 8'b10000000 → both words report match_cnt=0.
- Round robin: req=4'b1111 held high with distinct data → grants 0,1,2,3,0 in order, each done_id matching its grant; gnt is one-hot, one cycle each, 11 cycles apart.
- Pointer wrap: after serving requester 2, apply req=4'b0011 → gnt=0001, since the search runs 3,0,1,2. A later req=4'b0010 → gnt=0010.

Source files
------------

// File: rtl/pattern_scan_arbiter.sv
// Round-robin scheduler that shares one bit-serial overlapping pattern detector
// among four requesters and reports the per-word match count with the requester id.
module pattern_scan_arbiter #(
    parameter int              WORD_W = 8,
    parameter int              PAT_W  = 3,
    parameter logic [PAT_W-1:0] PAT   = 3'b101,
    parameter int              CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [3:0]            req,
    input  logic [4*WORD_W-1:0]   data,
    output logic [3:0]            gnt,
    output logic                  busy,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic                  done,
    output logic [1:0]            done_id,
    output logic [CNT_W-1:0]      match_cnt
);

    localparam int              BC_W     = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] WORD_C   = BC_W'(WORD_W);
    localparam logic [BC_W-1:0] MIN_SEEN = BC_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_ptr;
    logic [1:0]          r_winner;
    logic [WORD_W-1:0]   r_shift;
    logic [PAT_W-2:0]    r_win;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]    r_count;
    logic [3:0]          r_gnt;
    logic                r_busy;
    logic                r_ser_bit;
    logic                r_ser_valid;
    logic                r_done;
    logic [1:0]          r_done_id;
    logic [CNT_W-1:0]    r_match_cnt;

    logic [1:0]          w_idx;
    logic [1:0]          w_winner;
    logic [WORD_W-1:0]   w_word;
    logic                w_emit;
    logic                w_bit;
    logic [PAT_W-1:0]    w_win_next;
    logic                w_hit;

    // Round-robin winner search: the lowest offset from r_ptr with req set wins.
    always_comb begin
        w_idx    = r_ptr;
        w_winner = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_winner = w_idx;
            end else begin
                w_winner = w_winner;
            end
        end
        w_word = data[WORD_W-1:0];
        for (int k = 0; k < 4; k++) begin
            if (w_winner == 2'(k)) begin
                w_word = data[k*WORD_W +: WORD_W];
            end else begin
                w_word = w_word;
            end
        end
    end

    // Next-state and detector combinational logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD:  w_next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (r_bit_cnt == WORD_C) begin
                    w_next_state = ST_REPORT;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_REPORT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        // The bit leaving the shift register on this edge is what ser_bit shows next cycle.
        w_emit     = (r_state == ST_LOAD) || ((r_state == ST_SHIFT) && (r_bit_cnt != WORD_C));
        w_bit      = r_shift[WORD_W-1];
        w_win_next = {r_win, w_bit};
        w_hit      = (r_bit_cnt >= MIN_SEEN) && (w_win_next == PAT);
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr       <= 2'd0;
            r_winner    <= 2'd0;
            r_shift     <= '0;
            r_win       <= '0;
            r_bit_cnt   <= '0;
            r_count     <= '0;
            r_gnt       <= 4'b0000;
            r_busy      <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 2'd0;
            r_match_cnt <= '0;
        end else begin
            r_busy      <= (w_next_state != ST_IDLE);
            r_gnt       <= 4'b0000;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_winner  <= w_winner;
                        r_gnt     <= 4'b0001 << w_winner;
                        r_shift   <= w_word;
                        r_win     <= '0;
                        r_bit_cnt <= '0;
                        r_count   <= '0;
                    end else begin
                        r_winner  <= r_winner;
                    end
                end
                ST_LOAD, ST_SHIFT: begin
                    if (w_emit) begin
                        r_ser_bit   <= w_bit;
                        r_ser_valid <= 1'b1;
                        r_shift     <= {r_shift[WORD_W-2:0], 1'b0};
                        r_win       <= w_win_next[PAT_W-2:0];
                        r_bit_cnt   <= r_bit_cnt + BC_W'(1);
                        if (w_hit) begin
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_count <= r_count;
                        end
                    end else begin
                        r_done      <= 1'b1;
                        r_done_id   <= r_winner;
                        r_match_cnt <= r_count;
                    end
                end
                ST_REPORT: begin
                    r_ptr <= r_winner + 2'd1;
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign ser_bit   = r_ser_bit;
    assign ser_valid = r_ser_valid;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Self-checking bench for pattern_scan_arbiter: directed vector table, hand-written
// corner sequences and random words checked against a behavioural model.
module tb_pattern_scan_arbiter;

    localparam int             WORD_W = 8;
    localparam int             PAT_W  = 3;
    localparam logic [PAT_W-1:0] PAT  = 3'b101;
    localparam int             CNT_W  = 4;

    logic                clk;
    logic                clr;
    logic [3:0]          req;
    logic [4*WORD_W-1:0] data;
    logic [3:0]          gnt;
    logic                busy;
    logic                ser_bit;
    logic                ser_valid;
    logic                done;
    logic [1:0]          done_id;
    logic [CNT_W-1:0]    match_cnt;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] dv;
        int          exp_id;
        int          exp_cnt;
    } vec_t;

    pattern_scan_arbiter #(
        .WORD_W(WORD_W), .PAT_W(PAT_W), .PAT(PAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .clr(clr), .req(req), .data(data), .gnt(gnt), .busy(busy),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .done(done),
        .done_id(done_id), .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Count of (overlapping) positions where the pattern appears, read MSB-first.
    function automatic int model_count(input logic [WORD_W-1:0] w);
        int n;
        logic [PAT_W-1:0] s;
        n = 0;
        for (int i = 0; i <= WORD_W - PAT_W; i++) begin
            s = w[WORD_W-1-i -: PAT_W];
            if (s == PAT) n++;
        end
        return n;
    endfunction

    function automatic int model_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; drives one request and checks the whole word.
    task automatic serve(input logic [3:0] rq, input logic [31:0] dv, input bit drop,
                         input int exp_id, input int exp_cnt);
        logic [WORD_W-1:0] w;
        w    = dv[exp_id*WORD_W +: WORD_W];
        req  = rq;
        data = dv;
        @(negedge clk);
        check("gnt_onehot", {28'd0, gnt}, 32'd1 << exp_id);
        check("busy_load", {31'd0, busy}, 32'd1);
        check("valid_load", {31'd0, ser_valid}, 32'd0);
        if (drop) req = 4'b0000;
        for (int b = 0; b < WORD_W; b++) begin
            @(negedge clk);
            check("ser_valid", {31'd0, ser_valid}, 32'd1);
            check("ser_bit", {31'd0, ser_bit}, {31'd0, w[WORD_W-1-b]});
            check("gnt_pulse", {28'd0, gnt}, 32'd0);
            check("done_early", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("done_id", {30'd0, done_id}, exp_id);
        check("match_cnt", {28'd0, match_cnt}, exp_cnt);
        check("valid_report", {31'd0, ser_valid}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("done_id_hold", {30'd0, done_id}, exp_id);
        check("match_cnt_hold", {28'd0, match_cnt}, exp_cnt);
        ptr_m = (exp_id + 1) % 4;
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {22'd0, gnt, busy, ser_bit, ser_valid, done, done_id, match_cnt}, 32'd0);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        clr = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        @(negedge clk);
        @(negedge clk);
        clr   = 1'b1;
        ptr_m = 0;
    endtask

    vec_t vecs[6];

    initial begin
        logic [3:0]  rq;
        logic [31:0] dv;
        bit          drop;
        int          id;

        req  = 4'b0000;
        data = 32'd0;
        clr  = 1'b0;
        do_reset();
        @(negedge clk);
        check_all_zero("idle_after_reset");

        vecs[0] = '{rq: 4'b0001, dv: 32'h0000_00AA, exp_id: 0, exp_cnt: 3};
        vecs[1] = '{rq: 4'b0001, dv: 32'h0000_00B5, exp_id: 0, exp_cnt: 3};
        vecs[2] = '{rq: 4'b0001, dv: 32'h0000_00FF, exp_id: 0, exp_cnt: 0};
        vecs[3] = '{rq: 4'b0001, dv: 32'h0000_0005, exp_id: 0, exp_cnt: 1};
        vecs[4] = '{rq: 4'b0001, dv: 32'h0000_0002, exp_id: 0, exp_cnt: 0};
        vecs[5] = '{rq: 4'b0001, dv: 32'h0000_0080, exp_id: 0, exp_cnt: 0};
        for (int i = 0; i < 6; i++) begin
            serve(vecs[i].rq, vecs[i].dv, 1'b1, vecs[i].exp_id, vecs[i].exp_cnt);
        end

        // A request that is dropped before the sampling edge is never served.
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_req", {27'd0, gnt, busy}, 32'd0);
        end

        // Round robin with all requests held high, starting from a fresh pointer.
        do_reset();
        serve(4'b1111, 32'h05AA_B5FF, 1'b0, 0, 0);
        serve(4'b1111, 32'h05AA_B5FF, 1'b0, 1, 3);
        serve(4'b1111, 32'h05AA_B5FF, 1'b0, 2, 3);
        serve(4'b1111, 32'h05AA_B5FF, 1'b0, 3, 1);
        serve(4'b1111, 32'h05AA_B5FF, 1'b1, 0, 0);

        // Pointer wrap: after requester 2, search order is 3,0,1,2.
        serve(4'b0100, 32'h00AA_0000, 1'b1, 2, 3);
        serve(4'b0011, 32'h0000_05B5, 1'b1, 0, 3);
        serve(4'b0010, 32'h0000_05B5, 1'b1, 1, 1);

        // Reset during SHIFT bit 4 aborts the word with no done.
        req  = 4'b0001;
        data = 32'h0000_00AA;
        @(negedge clk);
        check("abort_gnt", {28'd0, gnt}, 32'd1);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("abort_valid_before", {31'd0, ser_valid}, 32'd1);
        #2;
        clr = 1'b0;
        #1;
        check_all_zero("abort_async_clear");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        clr   = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_all_zero("abort_stays_idle");
        end
        serve(4'b0010, 32'h0000_B500, 1'b1, 1, 3);

        // Random words against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            rq   = 4'($urandom_range(1, 15));
            dv   = $urandom;
            drop = 1'($urandom_range(0, 1));
            id   = model_winner(rq, ptr_m);
            serve(rq, dv, drop, id, model_count(dv[id*WORD_W +: WORD_W]));
        end

        req = 4'b0000;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
